// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, the NOP word
// and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_INST_W   = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    // Index of the IF/ID hold bit inside the pipeline stall vector
    localparam int STALL_IF_ID = 1;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'b00,
        IF_BUSY    = 2'b01,
        IF_DISCARD = 2'b10
    } if_state_t;

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: flush clears to a NOP bubble, hold keeps contents,
// otherwise loads either a delivered instruction or a bubble tagged with the current pc.
module if_fetch_if_id_reg
    import if_fetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0]  NOP_INST = DEF_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic              i_load_valid,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic [INST_W-1:0] i_load_inst,
    input  logic [ADDR_W-1:0] i_bubble_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_valid
);

    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            if (i_load_valid) begin
                r_pc    <= i_load_pc;
                r_inst  <= i_load_inst;
                r_valid <= 1'b1;
            end else begin
                r_pc    <= i_bubble_pc;
                r_inst  <= NOP_INST;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding req/ack fetch of the word at pc,
// one-entry hold buffer for downstream stalls, and drop of in-flight data on flush.
//
// state      | meaning
// IF_IDLE    | no request outstanding; issue one unless a held word is waiting or flushing
// IF_BUSY    | request outstanding; req/addr held stable until ack
// IF_DISCARD | request was flushed before its ack; swallow that ack and its data
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0]  NOP_INST = DEF_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [5:0]        stall,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [INST_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              stallreq_o
);

    if_state_t         r_state;
    if_state_t         w_state_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;

    logic              r_hold_valid;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [INST_W-1:0] r_hold_inst;

    logic              w_id_hold;
    logic              w_ack_busy;
    logic              w_complete;
    logic [ADDR_W-1:0] w_pc_aligned;
    logic              w_unused_bits;

    assign w_id_hold     = stall[STALL_IF_ID];
    assign w_ack_busy    = (r_state == IF_BUSY) && mem_ack_i;
    assign w_complete    = w_ack_busy && !flush_i;
    assign w_pc_aligned  = {pc_i[ADDR_W-1:2], 2'b00};
    assign w_unused_bits = ^{stall[5:2], stall[0], pc_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IF_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            IF_IDLE: begin
                if (!r_hold_valid && !flush_i) begin
                    w_state_nxt    = IF_BUSY;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_pc_aligned;
                end
            end
            IF_BUSY: begin
                // A flush coinciding with the ack simply discards the data here.
                if (mem_ack_i) begin
                    w_state_nxt   = IF_IDLE;
                    w_mem_req_nxt = 1'b0;
                end else if (flush_i) begin
                    w_state_nxt   = IF_DISCARD;
                    w_mem_req_nxt = 1'b0;
                end
            end
            IF_DISCARD: begin
                if (mem_ack_i) begin
                    w_state_nxt = IF_IDLE;
                end
            end
            default: begin
                w_state_nxt   = IF_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // A word that completes while ID is stalled parks here until the stall clears.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_hold_valid <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_inst  <= NOP_INST;
        end else if (w_complete && w_id_hold) begin
            r_hold_valid <= 1'b1;
            r_hold_pc    <= r_mem_addr;
            r_hold_inst  <= mem_rdata_i;
        end else if (r_hold_valid && !w_id_hold) begin
            r_hold_valid <= 1'b0;
        end
    end

    if_fetch_if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (w_id_hold),
        .i_flush      (flush_i),
        .i_load_valid (w_complete || r_hold_valid),
        .i_load_pc    (w_complete ? r_mem_addr : r_hold_pc),
        .i_load_inst  (w_complete ? mem_rdata_i : r_hold_inst),
        .i_bubble_pc  (pc_i),
        .o_pc         (if_pc_o),
        .o_inst       (if_inst_o),
        .o_valid      (if_valid_o)
    );

    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = r_mem_addr;
    assign stallreq_o = !flush_i && !r_hold_valid && !w_ack_busy;

endmodule
